// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed 7-segment driver with guard blank,
// 4-bit PWM brightness, leading-zero blanking and per-frame snapshotting.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | display dark, prescaler/subslot/digit counters held at zero
// RUN   | scanning digits; snapshot reloaded at every frame start
module seg7_scan_mux #(
  parameter int NUM_DIGITS     = 7,
  parameter int SUBSLOT_CYCLES = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic [7:0] DIG0,
  input  logic [7:0] DIG1,
  input  logic [7:0] DIG2,
  input  logic [7:0] DIG3,
  input  logic [7:0] DIG4,
  input  logic [7:0] DIG5,
  input  logic [7:0] DIG6,
  input  logic [3:0] BRIGHTNESS,
  input  logic       BLANK_LZ,
  output logic [7:0] SEG,
  output logic [6:0] DIGIT_SEL,
  output logic [2:0] CUR_DIGIT,
  output logic       FRAME_DONE
);

  localparam int          PW    = $clog2(SUBSLOT_CYCLES);
  localparam logic [PW-1:0] P_MAX = PW'(SUBSLOT_CYCLES - 1);
  localparam logic [2:0]  D_MAX = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]  SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [6:0]  DIG_OFF = {7{DIG_ACTIVE_LOW}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   p_q, p_d;
  logic [3:0]      s_q, s_d;
  logic [2:0]      d_q, d_d;
  logic [3:0]      bri_q;
  logic [6:0][7:0] snap_q;
  logic [6:0][7:0] dig_in;

  logic            load_frame;
  logic            load_slot;
  logic            frame_wrap;
  logic            lit;
  logic            run_active;
  logic [6:0]      blank;
  logic            lz_run;
  logic [7:0]      pat;
  logic [7:0]      seg_on;
  logic [6:0]      sel_on;

  assign dig_in = {DIG6, DIG5, DIG4, DIG3, DIG2, DIG1, DIG0};

  // State and scan counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      s_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      s_q     <= s_d;
      d_q     <= d_d;
    end
  end

  // Next-state and counter sequencing; flags mark slot and frame boundaries.
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    s_d        = s_q;
    d_d        = d_q;
    load_frame = 1'b0;
    load_slot  = 1'b0;
    frame_wrap = 1'b0;
    case (state_q)
      ST_IDLE: begin
        p_d = '0;
        s_d = '0;
        d_d = '0;
        if (ENABLE) begin
          state_d    = ST_RUN;
          load_frame = 1'b1;
          load_slot  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!ENABLE) begin
          state_d = ST_IDLE;
          p_d     = '0;
          s_d     = '0;
          d_d     = '0;
        end else if (p_q == P_MAX) begin
          p_d = '0;
          if (s_q == 4'd15) begin
            s_d       = '0;
            load_slot = 1'b1;
            if (d_q == D_MAX) begin
              d_d        = '0;
              load_frame = 1'b1;
              frame_wrap = 1'b1;
            end else begin
              d_d = d_q + 3'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end else begin
          p_d = p_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame snapshot of the digit patterns and slot-start brightness latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snap_q <= '0;
      bri_q  <= '0;
    end else begin
      if (load_frame) begin
        for (int k = 0; k < 7; k++) begin
          snap_q[k] <= (k < NUM_DIGITS) ? dig_in[k] : 8'h00;
        end
      end
      if (load_slot) begin
        bri_q <= BRIGHTNESS;
      end
    end
  end

  // Leading-zero chain: walks down from the top digit while digits read "0".
  always_comb begin
    blank  = '0;
    lz_run = BLANK_LZ;
    for (int k = 6; k >= 1; k--) begin
      if (k <= NUM_DIGITS - 1) begin
        lz_run   = lz_run && (snap_q[k][7:1] == 7'b1111110);
        blank[k] = lz_run;
      end
    end
  end

  // Lit decision and logical (active-high) segment/select values.
  always_comb begin
    run_active = (state_q == ST_RUN) && ENABLE;
    lit        = run_active && (s_q != 4'd0) && (s_q <= bri_q);
    pat        = snap_q[d_q];
    seg_on     = '0;
    sel_on     = '0;
    if (lit) begin
      if (blank[d_q]) begin
        // Blanked digit keeps only its decimal point; fully dark otherwise.
        seg_on = {7'b0, pat[0]};
        sel_on = pat[0] ? (7'b1 << d_q) : 7'b0;
      end else begin
        seg_on = pat;
        sel_on = 7'b1 << d_q;
      end
    end
  end

  // Output registers; polarity inversion happens only here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      SEG        <= SEG_OFF;
      DIGIT_SEL  <= DIG_OFF;
      CUR_DIGIT  <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      SEG        <= seg_on ^ SEG_OFF;
      DIGIT_SEL  <= sel_on ^ DIG_OFF;
      CUR_DIGIT  <= run_active ? d_q : 3'd0;
      FRAME_DONE <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed testbench for seg7_scan_mux with 4-cycle subslots, 7 digits,
// active-low segments and selects (slot = 64 cycles, frame = 448 cycles).
module tb_seg7_scan_mux;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ENABLE;
  logic [7:0] DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6;
  logic [3:0] BRIGHTNESS;
  logic       BLANK_LZ;
  logic [7:0] SEG;
  logic [6:0] DIGIT_SEL;
  logic [2:0] CUR_DIGIT;
  logic       FRAME_DONE;

  int total = 0;
  int bad   = 0;
  int rc    = 0;

  localparam logic [7:0] PAT [7] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE};

  seg7_scan_mux #(
    .NUM_DIGITS(7),
    .SUBSLOT_CYCLES(4),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
    .DIG0(DIG0), .DIG1(DIG1), .DIG2(DIG2), .DIG3(DIG3),
    .DIG4(DIG4), .DIG5(DIG5), .DIG6(DIG6),
    .BRIGHTNESS(BRIGHTNESS), .BLANK_LZ(BLANK_LZ),
    .SEG(SEG), .DIGIT_SEL(DIGIT_SEL), .CUR_DIGIT(CUR_DIGIT), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    rc++;
  endtask

  task automatic load_count_digits();
    DIG0 = PAT[0]; DIG1 = PAT[1]; DIG2 = PAT[2]; DIG3 = PAT[3];
    DIG4 = PAT[4]; DIG5 = PAT[5]; DIG6 = PAT[6];
  endtask

  // Reset with ENABLE low, then enable; rc=0 right after the IDLE->RUN edge.
  task automatic start_run();
    RST = 1'b1;
    ENABLE = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();
    ENABLE = 1'b1;
    tick();
    rc = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1; ENABLE = 1'b1; BRIGHTNESS = 4'd15; BLANK_LZ = 1'b0;
    load_count_digits();
    tick();
    tick();
    total++;
    if (SEG !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=ff", SEG); end
    total++;
    if (DIGIT_SEL !== 7'h7F) begin bad++; $display("FAIL reset_sel got=%h want=7f", DIGIT_SEL); end
    total++;
    if (CUR_DIGIT !== 3'd0) begin bad++; $display("FAIL reset_cur got=%0d want=0", CUR_DIGIT); end
    total++;
    if (FRAME_DONE !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", FRAME_DONE); end
  endtask

  task automatic test_scan();
    int prev, k, s;
    logic [7:0] exp_seg;
    logic [6:0] one7, exp_sel;
    logic exp_fd;
    BRIGHTNESS = 4'd15; BLANK_LZ = 1'b0;
    load_count_digits();
    start_run();
    for (int n = 1; n <= 900; n++) begin
      tick();
      prev = rc - 1;
      k = (prev / 64) % 7;
      s = (prev % 64) / 4;
      one7 = 7'b1 << k;
      exp_seg = (s != 0) ? ~PAT[k] : 8'hFF;
      exp_sel = (s != 0) ? ~one7 : 7'h7F;
      exp_fd = (rc % 448) == 0;
      total++;
      if (SEG !== exp_seg || DIGIT_SEL !== exp_sel) begin
        bad++;
        $display("FAIL scan_out n=%0d seg=%h/%h sel=%h/%h", rc, SEG, exp_seg, DIGIT_SEL, exp_sel);
      end
      total++;
      if (CUR_DIGIT !== 3'(k)) begin bad++; $display("FAIL scan_cur n=%0d got=%0d want=%0d", rc, CUR_DIGIT, k); end
      total++;
      if (FRAME_DONE !== exp_fd) begin bad++; $display("FAIL scan_fd n=%0d got=%b want=%b", rc, FRAME_DONE, exp_fd); end
    end
  endtask

  task automatic test_brightness();
    int prev, k, s, bri;
    logic lit;
    logic [6:0] one7, exp_sel;
    logic [7:0] exp_seg;
    BLANK_LZ = 1'b0;
    load_count_digits();
    // Duty of 3: guard 4, lit 12, dark 48 per slot.
    BRIGHTNESS = 4'd3;
    start_run();
    for (int n = 1; n <= 128; n++) begin
      tick();
      prev = rc - 1; k = (prev / 64) % 7; s = (prev % 64) / 4;
      lit = (s >= 1) && (s <= 3);
      one7 = 7'b1 << k;
      exp_seg = lit ? ~PAT[k] : 8'hFF;
      exp_sel = lit ? ~one7 : 7'h7F;
      total++;
      if (SEG !== exp_seg || DIGIT_SEL !== exp_sel) begin
        bad++;
        $display("FAIL bri3 n=%0d seg=%h/%h sel=%h/%h", rc, SEG, exp_seg, DIGIT_SEL, exp_sel);
      end
    end
    // Brightness 0 never lights.
    BRIGHTNESS = 4'd0;
    start_run();
    for (int n = 1; n <= 200; n++) begin
      tick();
      total++;
      if (SEG !== 8'hFF || DIGIT_SEL !== 7'h7F) begin
        bad++;
        $display("FAIL bri0 n=%0d seg=%h/ff sel=%h/7f", rc, SEG, DIGIT_SEL);
      end
    end
    // Mid-slot change takes effect only at the next slot.
    BRIGHTNESS = 4'd15;
    start_run();
    for (int n = 1; n <= 128; n++) begin
      tick();
      if (rc == 20) BRIGHTNESS = 4'd2;
      prev = rc - 1; k = (prev / 64) % 7; s = (prev % 64) / 4;
      bri = (prev < 64) ? 15 : 2;
      lit = (s >= 1) && (s <= bri);
      one7 = 7'b1 << k;
      exp_seg = lit ? ~PAT[k] : 8'hFF;
      exp_sel = lit ? ~one7 : 7'h7F;
      total++;
      if (SEG !== exp_seg || DIGIT_SEL !== exp_sel) begin
        bad++;
        $display("FAIL bri_mid n=%0d seg=%h/%h sel=%h/%h", rc, SEG, exp_seg, DIGIT_SEL, exp_sel);
      end
    end
  endtask

  task automatic test_lz_blank();
    int prev, k, s, f;
    logic [7:0] lit_seg [2][7];
    logic       lit_act [2][7];
    logic [6:0] one7, exp_sel;
    logic [7:0] exp_seg;
    // Frame 0: digits 6..2 dark, digit 1 DP only, digit 0 full "0".
    lit_seg[0] = '{8'h03, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    lit_act[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Frame 1: DIG2="5" stops the chain, so digits 2 and 1 display normally.
    lit_seg[1] = '{8'h03, 8'h02, 8'h49, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    lit_act[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    BRIGHTNESS = 4'd15; BLANK_LZ = 1'b1;
    DIG0 = 8'hFC; DIG1 = 8'hFD; DIG2 = 8'hFC; DIG3 = 8'hFC;
    DIG4 = 8'hFC; DIG5 = 8'hFC; DIG6 = 8'hFC;
    start_run();
    for (int n = 1; n <= 896; n++) begin
      tick();
      if (rc == 10) DIG2 = 8'hB6;
      prev = rc - 1; k = (prev / 64) % 7; s = (prev % 64) / 4; f = prev / 448;
      one7 = 7'b1 << k;
      exp_seg = (s != 0) ? lit_seg[f][k] : 8'hFF;
      exp_sel = (s != 0 && lit_act[f][k]) ? ~one7 : 7'h7F;
      total++;
      if (SEG !== exp_seg || DIGIT_SEL !== exp_sel) begin
        bad++;
        $display("FAIL lz n=%0d seg=%h/%h sel=%h/%h", rc, SEG, exp_seg, DIGIT_SEL, exp_sel);
      end
    end
  endtask

  task automatic test_tearing();
    int prev, k, s;
    logic [7:0] exp_seg, pk;
    logic [6:0] one7, exp_sel;
    BRIGHTNESS = 4'd15; BLANK_LZ = 1'b0;
    load_count_digits();
    start_run();
    for (int n = 1; n <= 720; n++) begin
      tick();
      if (rc == 100) DIG3 = 8'hFE;
      prev = rc - 1; k = (prev / 64) % 7; s = (prev % 64) / 4;
      pk = (k == 3 && prev >= 448) ? 8'hFE : PAT[k];
      one7 = 7'b1 << k;
      exp_seg = (s != 0) ? ~pk : 8'hFF;
      exp_sel = (s != 0) ? ~one7 : 7'h7F;
      total++;
      if (SEG !== exp_seg || DIGIT_SEL !== exp_sel) begin
        bad++;
        $display("FAIL tear n=%0d seg=%h/%h sel=%h/%h", rc, SEG, exp_seg, DIGIT_SEL, exp_sel);
      end
      if (rc == 448) begin
        total++;
        if (FRAME_DONE !== 1'b1) begin bad++; $display("FAIL tear_fd got=%b want=1", FRAME_DONE); end
      end
    end
  endtask

  task automatic test_enable_toggle();
    BRIGHTNESS = 4'd15; BLANK_LZ = 1'b0;
    load_count_digits();
    start_run();
    while (rc < 286) tick();
    total++;
    if (SEG !== 8'h99 || DIGIT_SEL !== 7'h6F || CUR_DIGIT !== 3'd4) begin
      bad++;
      $display("FAIL en_pre seg=%h/99 sel=%h/6f cur=%0d/4", SEG, DIGIT_SEL, CUR_DIGIT);
    end
    ENABLE = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      total++;
      if (SEG !== 8'hFF || DIGIT_SEL !== 7'h7F || CUR_DIGIT !== 3'd0 || FRAME_DONE !== 1'b0) begin
        bad++;
        $display("FAIL en_off n=%0d seg=%h/ff sel=%h/7f cur=%0d/0 fd=%b/0", n, SEG, DIGIT_SEL, CUR_DIGIT, FRAME_DONE);
      end
    end
    DIG0 = 8'hF6;
    ENABLE = 1'b1;
    tick();
    rc = 0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (rc <= 4) begin
        total++;
        if (SEG !== 8'hFF || DIGIT_SEL !== 7'h7F || CUR_DIGIT !== 3'd0) begin
          bad++;
          $display("FAIL en_guard n=%0d seg=%h/ff sel=%h/7f cur=%0d/0", rc, SEG, DIGIT_SEL, CUR_DIGIT);
        end
      end else begin
        total++;
        if (SEG !== 8'h09 || DIGIT_SEL !== 7'h7E) begin
          bad++;
          $display("FAIL en_relit n=%0d seg=%h/09 sel=%h/7e", rc, SEG, DIGIT_SEL);
        end
      end
    end
  endtask

  task automatic test_reset_midslot();
    BRIGHTNESS = 4'd15; BLANK_LZ = 1'b0;
    load_count_digits();
    start_run();
    while (rc < 340) tick();
    total++;
    if (SEG !== 8'h49 || DIGIT_SEL !== 7'h5F) begin
      bad++;
      $display("FAIL rst_pre seg=%h/49 sel=%h/5f", SEG, DIGIT_SEL);
    end
    RST = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      total++;
      if (SEG !== 8'hFF || DIGIT_SEL !== 7'h7F || CUR_DIGIT !== 3'd0 || FRAME_DONE !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid n=%0d seg=%h/ff sel=%h/7f cur=%0d/0 fd=%b/0", n, SEG, DIGIT_SEL, CUR_DIGIT, FRAME_DONE);
      end
    end
    RST = 1'b0;
    tick();
    rc = 0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      if (rc < 5) begin
        total++;
        if (SEG !== 8'hFF || DIGIT_SEL !== 7'h7F || FRAME_DONE !== 1'b0) begin
          bad++;
          $display("FAIL rst_guard n=%0d seg=%h/ff sel=%h/7f fd=%b/0", rc, SEG, DIGIT_SEL, FRAME_DONE);
        end
      end else begin
        total++;
        if (SEG !== 8'h03 || DIGIT_SEL !== 7'h7E) begin
          bad++;
          $display("FAIL rst_lit n=%0d seg=%h/03 sel=%h/7e", rc, SEG, DIGIT_SEL);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1; ENABLE = 1'b0; BRIGHTNESS = 4'd0; BLANK_LZ = 1'b0;
    DIG0 = 8'h00; DIG1 = 8'h00; DIG2 = 8'h00; DIG3 = 8'h00;
    DIG4 = 8'h00; DIG5 = 8'h00; DIG6 = 8'h00;
    test_reset();
    test_scan();
    test_brightness();
    test_lz_blank();
    test_tearing();
    test_enable_toggle();
    test_reset_midslot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
